// File: rtl/adv7513_init_seq.sv
// ADV7513 power-up register programming sequencer.
// Waits for a stable hot-plug detect, then issues one 2-byte I2C write per ROM entry,
// retrying failed entries, and replays the whole table on every HPD re-assert.
module adv7513_init_seq #(
    parameter int unsigned NUM_REGS    = 25,
    parameter logic [6:0]  SLAVE_ADDR  = 7'h7A,
    parameter int unsigned POWERUP_CYC = 10_000_000,
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned GAP_CYC     = 5_000
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        hpd,
    output logic [7:0]  rom_index,
    input  logic [15:0] rom_data,
    output logic        i2c_start,
    output logic [6:0]  i2c_slave_addr,
    output logic [7:0]  i2c_byte0,
    output logic [7:0]  i2c_byte1,
    input  logic        i2c_done,
    input  logic        i2c_fail,
    output logic        init_done,
    output logic        init_error,
    output logic [7:0]  fail_count
);

    // One shared cycle counter serves power-up wait, ack timeout and inter-write gap.
    localparam int unsigned CYC_MAX = (POWERUP_CYC > TIMEOUT_CYC)
        ? ((POWERUP_CYC > GAP_CYC) ? POWERUP_CYC : GAP_CYC)
        : ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);
    localparam int unsigned CNT_W   = $clog2(CYC_MAX) + 1;
    localparam int unsigned RTRY_W  = $clog2(MAX_RETRIES) + 1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAIT_PWR = 4'd1;
    localparam logic [3:0] S_LOAD     = 4'd2;
    localparam logic [3:0] S_ISSUE    = 4'd3;
    localparam logic [3:0] S_WAIT_ACK = 4'd4;
    localparam logic [3:0] S_NEXT     = 4'd5;
    localparam logic [3:0] S_RETRY    = 4'd6;
    localparam logic [3:0] S_GAP      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;
    localparam logic [3:0] S_ERROR    = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTRY_W-1:0] retry_q, retry_d;
    logic [7:0]        rom_index_q, rom_index_d;
    logic              start_q, start_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic              init_done_q, init_done_d;
    logic              init_error_q, init_error_d;
    logic [7:0]        fail_count_q, fail_count_d;
    logic              hpd_lost_q, hpd_lost_d;
    logic              hpd_meta_q, hpd_s_q;
    logic              lost;

    assign rom_index      = rom_index_q;
    assign i2c_start      = start_q;
    assign i2c_slave_addr = SLAVE_ADDR;
    assign i2c_byte0      = byte0_q;
    assign i2c_byte1      = byte1_q;
    assign init_done      = init_done_q;
    assign init_error     = init_error_q;
    assign fail_count     = fail_count_q;

    // Next-state and registered-output logic; i2c_start is set on the way into ISSUE so it is high only there.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        rom_index_d  = rom_index_q;
        start_d      = 1'b0;
        byte0_d      = byte0_q;
        byte1_d      = byte1_q;
        fail_count_d = fail_count_q;
        hpd_lost_d   = hpd_lost_q;
        lost         = hpd_lost_q | ~hpd_s_q;

        case (state_q)
            S_IDLE: begin
                rom_index_d = 8'd0;
                retry_d     = '0;
                cnt_d       = '0;
                if (hpd_s_q) state_d = S_WAIT_PWR;
            end
            S_WAIT_PWR: begin
                if (!hpd_s_q)                                 state_d = S_IDLE;
                else if (cnt_q == CNT_W'(POWERUP_CYC - 1))    state_d = S_LOAD;
                else                                          cnt_d = cnt_q + CNT_W'(1);
            end
            S_LOAD: begin
                byte0_d = rom_data[15:8];
                byte1_d = rom_data[7:0];
                start_d = 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d      = '0;
                hpd_lost_d = 1'b0;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An HPD drop never aborts the bus transaction; it only redirects the outcome to IDLE.
                hpd_lost_d = lost;
                if (i2c_fail || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = lost ? S_IDLE : S_RETRY;
                else if (i2c_done)                                state_d = lost ? S_IDLE : S_NEXT;
                else                                              cnt_d = cnt_q + CNT_W'(1);
            end
            S_NEXT: begin
                retry_d = '0;
                cnt_d   = '0;
                if (rom_index_q == 8'(NUM_REGS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    rom_index_d = rom_index_q + 8'd1;
                    state_d     = S_GAP;
                end
            end
            S_RETRY: begin
                cnt_d        = '0;
                fail_count_d = (fail_count_q == 8'hFF) ? 8'hFF : fail_count_q + 8'd1;
                if (retry_q == RTRY_W'(MAX_RETRIES)) begin
                    state_d = S_ERROR;
                end else begin
                    retry_d = retry_q + RTRY_W'(1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!hpd_s_q)                             state_d = S_IDLE;
                else if (cnt_q == CNT_W'(GAP_CYC - 1))    state_d = S_LOAD;
                else                                      cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                if (!hpd_s_q) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (!hpd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        init_done_d  = (state_d == S_DONE);
        init_error_d = (state_d == S_ERROR);
    end

    // State, output and HPD synchroniser registers with synchronous reset.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            rom_index_q  <= 8'd0;
            start_q      <= 1'b0;
            byte0_q      <= 8'd0;
            byte1_q      <= 8'd0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            fail_count_q <= 8'd0;
            hpd_lost_q   <= 1'b0;
            hpd_meta_q   <= 1'b0;
            hpd_s_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            rom_index_q  <= rom_index_d;
            start_q      <= start_d;
            byte0_q      <= byte0_d;
            byte1_q      <= byte1_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            fail_count_q <= fail_count_d;
            hpd_lost_q   <= hpd_lost_d;
            hpd_meta_q   <= hpd;
            hpd_s_q      <= hpd_meta_q;
        end
    end

endmodule
